// File: rtl/rf_pkg.sv
// Shared register-file types and widths, imported by register_file and its
// writeback queue so both agree on the entry layout.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Producer / register-file / decode-bypass signal bundle of the writeback queue.
// The slave modport is the queue itself; the master modport is its environment.
interface reg_wb_queue_if
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rd;
  logic [XLEN-1:0] in_data;

  logic            drain_en;
  logic            wr_en;
  logic [AW-1:0]   wr_reg;
  logic [XLEN-1:0] wr_data;

  logic [AW-1:0]   rd_reg_1;
  logic [AW-1:0]   rd_reg_2;
  logic            fwd_hit_1;
  logic [XLEN-1:0] fwd_data_1;
  logic            fwd_hit_2;
  logic [XLEN-1:0] fwd_data_2;

  logic [CW-1:0]   count;
  logic            empty;
  logic            full;

  modport slave (
    input  in_valid, in_rd, in_data, drain_en, rd_reg_1, rd_reg_2,
    output in_ready, wr_en, wr_reg, wr_data,
           fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2,
           count, empty, full
  );

  modport master (
    output in_valid, in_rd, in_data, drain_en, rd_reg_1, rd_reg_2,
    input  in_ready, wr_en, wr_reg, wr_data,
           fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2,
           count, empty, full
  );

endinterface

// File: rtl/wb_fwd_lookup.sv
// Bypass lookup for one decode read port: finds the youngest pending entry
// whose destination matches the read address.
module wb_fwd_lookup
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [AW-1:0]              rd_addr,
  output logic                       hit,
  output logic [XLEN-1:0]            data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides older ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (rd_addr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if (valid[idx] && (entries[idx].rd == rd_addr)) begin
          hit  = 1'b1;
          data = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the register file write port, with a bypass
// lookup over pending results for both decode read ports.
module reg_wb_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic             is_empty;
  logic             is_full;
  logic             push;
  logic             pop;

  logic             hit_1;
  logic             hit_2;
  logic [XLEN-1:0]  fwd_1;
  logic [XLEN-1:0]  fwd_2;

  // A full queue refuses new work even while draining; x0 results are
  // acknowledged but never stored.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign push     = bus.in_valid && !is_full && (bus.in_rd != '0);
  assign pop      = bus.drain_en && !is_empty;

  assign bus.in_ready = !is_full;
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;

  assign bus.wr_en   = pop;
  assign bus.wr_reg  = is_empty ? '0 : entries[head_q].rd;
  assign bus.wr_data = is_empty ? '0 : entries[head_q].data;

  // Pointer and occupancy bookkeeping; pointers wrap by natural rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage and the valid mask seen by the bypass lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      valid_q <= '0;
    end else begin
      if (pop) valid_q[head_q] <= 1'b0;
      if (push) begin
        entries[tail_q] <= '{rd: bus.in_rd, data: bus.in_data};
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_fwd_1 (
    .entries (entries),
    .valid   (valid_q),
    .head    (head_q),
    .rd_addr (bus.rd_reg_1),
    .hit     (hit_1),
    .data    (fwd_1)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_fwd_2 (
    .entries (entries),
    .valid   (valid_q),
    .head    (head_q),
    .rd_addr (bus.rd_reg_2),
    .hit     (hit_2),
    .data    (fwd_2)
  );

  assign bus.fwd_hit_1  = hit_1;
  assign bus.fwd_data_1 = fwd_1;
  assign bus.fwd_hit_2  = hit_2;
  assign bus.fwd_data_2 = fwd_2;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model.
module tb_reg_wb_queue;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  wb_entry_t   mq [$];
  logic [31:0] model_rf [32] = '{default: '0};
  logic [31:0] bench_rf [32] = '{default: '0};

  logic        cur_valid;
  logic [4:0]  cur_rd;
  logic [31:0] cur_data;
  logic        cur_drain;
  logic [4:0]  cur_r1;
  logic [4:0]  cur_r2;

  // Register file stand-in, fed only by the DUT write port.
  always @(posedge clk)
    if (bus.wr_en) bench_rf[bus.wr_reg] <= bus.wr_data;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == a) begin
          hit = 1'b1;
          d   = mq[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic checkAll(input string phase);
    int          n;
    logic        h1, h2;
    logic [31:0] d1, d2;
    n = mq.size();
    model_fwd(cur_r1, h1, d1);
    model_fwd(cur_r2, h2, d2);
    checkOutput({phase, ".in_ready"},   bus.in_ready,   64'(n < DEPTH));
    checkOutput({phase, ".empty"},      bus.empty,      64'(n == 0));
    checkOutput({phase, ".full"},       bus.full,       64'(n == DEPTH));
    checkOutput({phase, ".count"},      bus.count,      64'(n));
    checkOutput({phase, ".wr_en"},      bus.wr_en,      64'(cur_drain && n > 0));
    checkOutput({phase, ".wr_reg"},     bus.wr_reg,     (n > 0) ? 64'(mq[0].rd)   : 64'd0);
    checkOutput({phase, ".wr_data"},    bus.wr_data,    (n > 0) ? 64'(mq[0].data) : 64'd0);
    checkOutput({phase, ".fwd_hit_1"},  bus.fwd_hit_1,  64'(h1));
    checkOutput({phase, ".fwd_data_1"}, bus.fwd_data_1, 64'(d1));
    checkOutput({phase, ".fwd_hit_2"},  bus.fwd_hit_2,  64'(h2));
    checkOutput({phase, ".fwd_data_2"}, bus.fwd_data_2, 64'(d2));
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic drain, input logic [4:0] r1, input logic [4:0] r2);
    cur_valid = v;     cur_rd = rd;     cur_data = d;
    cur_drain = drain; cur_r1 = r1;     cur_r2 = r2;
    bus.in_valid = v;  bus.in_rd = rd;  bus.in_data = d;
    bus.drain_en = drain; bus.rd_reg_1 = r1; bus.rd_reg_2 = r2;
  endtask

  // One clock: drive, check at the falling edge, advance the model, cross the rising edge.
  task automatic applyStimulus(input string phase, input logic v, input logic [4:0] rd,
                               input logic [31:0] d, input logic drain,
                               input logic [4:0] r1, input logic [4:0] r2,
                               output logic accepted);
    int   n;
    logic wr;
    drive(v, rd, d, drain, r1, r2);
    @(negedge clk);
    checkAll(phase);
    n        = mq.size();
    wr       = drain && (n > 0);
    accepted = v && (n < DEPTH);
    if (wr) begin
      model_rf[mq[0].rd] = mq[0].data;
      void'(mq.pop_front());
    end
    if (accepted && rd != 5'd0) mq.push_back('{rd: rd, data: d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        acc;
    logic        pending;
    logic        hv;
    logic [4:0]  hrd;
    logic [31:0] hd;
    int          guard;

    // Reset: drain requested and addresses set, yet everything must stay quiet.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7);
    #3;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single entry: bypass while held, then one drain cycle, then empty.
    applyStimulus("push5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, acc);
    checkOutput("push5.accepted", 64'(acc), 64'd1);
    applyStimulus("hold5", 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5, acc);
    checkOutput("hold5.fwd_data_1", bus.fwd_data_1, 64'hDEADBEEF);
    applyStimulus("drain5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, acc);
    applyStimulus("after5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, acc);
    checkOutput("after5.rf5", bench_rf[5], 64'hDEADBEEF);

    // Fill to capacity, then a fifth push that waits for a drain; wraps pointers.
    for (int i = 1; i <= 4; i++)
      applyStimulus("fill", 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'(i), 5'd3, acc);
    acc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus("fullhold", 1'b1, 5'd5, 32'h105, 1'b0, 5'd1, 5'd4, acc);
      checkOutput("fullhold.accepted", 64'(acc), 64'd0);
    end
    guard = 0;
    do begin
      applyStimulus("fulldrain", 1'b1, 5'd5, 32'h105, 1'b1, 5'd5, 5'd2, acc);
      guard++;
    end while (!acc && guard < 10);
    checkOutput("fulldrain.accepted_in_time", 64'(acc), 64'd1);
    for (int i = 0; i < 6; i++)
      applyStimulus("retire", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd4, acc);

    // Same destination twice: youngest bypasses, oldest retires first.
    applyStimulus("dup_a", 1'b1, 5'd7, 32'h1111, 1'b0, 5'd7, 5'd0, acc);
    applyStimulus("dup_b", 1'b1, 5'd7, 32'h2222, 1'b0, 5'd7, 5'd7, acc);
    applyStimulus("dup_chk", 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7, acc);
    checkOutput("dup.fwd_data_1", bus.fwd_data_1, 64'h2222);
    for (int i = 0; i < 3; i++)
      applyStimulus("dup_drain", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, acc);
    checkOutput("dup.rf7", bench_rf[7], 64'h2222);

    // x0 result: handshake completes but nothing is queued.
    applyStimulus("x0_push", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, acc);
    checkOutput("x0.accepted", 64'(acc), 64'd1);
    applyStimulus("x0_after", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, acc);

    // Random traffic; a refused request holds its rd/data until accepted.
    pending = 1'b0;
    hv = 1'b0; hrd = '0; hd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        hv  = ($urandom_range(0, 3) != 0);
        hrd = 5'($urandom_range(0, 7));
        hd  = $urandom;
      end
      applyStimulus("rand", hv, hrd, hd, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      pending = hv && !acc;
    end
    guard = 0;
    while (mq.size() > 0 && guard < 20) begin
      applyStimulus("flush", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, acc);
      guard++;
    end
    checkOutput("flush.model_empty", 64'(mq.size()), 64'd0);

    // Reset in the middle of a draining cycle discards the pending entries.
    for (int i = 0; i < 3; i++)
      applyStimulus("prefill", 1'b1, 5'(10 + i), 32'hA000 + 32'(i), 1'b0, 5'd10, 5'd12, acc);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd11);
    @(negedge clk);
    checkAll("predrop");
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    checkAll("midreset");
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      applyStimulus("postreset", 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd11, acc);

    for (int r = 0; r < 32; r++)
      checkOutput($sformatf("rf[%0d]", r), bench_rf[r], 64'(model_rf[r]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
